// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one side of an elastic pipeline stage: valid/ready plus {ctrl, data} payload.
// Latency: none, this is wiring only.
// Backpressure: the slave drives ready and the master holds its payload until valid & ready.
//
// Signals:
//   valid : entry present (master -> slave)
//   ready : slave can take the entry this cycle (slave -> master)
//   ctrl  : control bits, CTRL_W wide (master -> slave)
//   data  : data/operands, DATA_W wide (master -> slave)
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush and NOP-bubble insertion.
// Latency: an accepted entry reaches the outputs 1 cycle after acceptance; 1 entry/cycle sustained.
// Backpressure: in_ready is ~skid_valid, a pure flop output; a stalled output holds its payload stable.
//
// Ports:
//   clk_i        : rising-edge clock
//   rst_ni       : asynchronous active-low reset
//   flush_i      : synchronous kill of every held entry, wins over all transitions
//   in_if        : upstream side (slave modport): valid/ctrl/data in, ready out
//   out_if       : downstream side (master modport): valid/ctrl/data out, ready in
//   occupancy_o  : number of held entries (0, 1 or 2)
//   stall_cnt_o  : cycles with out_valid & ~out_ready (only with PIPE_STAGE_PERF_CNT_EN)
//   bubble_cnt_o : cycles with out_valid=0 and no flush (only with PIPE_STAGE_PERF_CNT_EN)
//
// Optional feature macro: PIPE_STAGE_PERF_CNT_EN adds the two saturating 32-bit counters.
//
// Parameters:
//   CTRL_W     : control width; control reads 0 whenever the output is a bubble
//   DATA_W     : data width; data is held across bubbles
//   CLEAR_DATA : when nonzero, data also reads 0 while the output is a bubble
module pipe_stage_elastic #(
  parameter int CTRL_W     = 12,
  parameter int DATA_W     = 128,
  parameter int CLEAR_DATA = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [1:0]           occupancy_o
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          bubble_cnt_o
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  // State encoding equals the occupancy count so occupancy_o is a direct flop output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q;
  entry_t main_q;
  entry_t skid_q;
  logic   main_vld_q;
  logic   skid_vld_q;

  entry_t in_ent;
  logic   acc;
  logic   rel;

  assign in_ent = {in_if.ctrl, in_if.data};
  assign acc    = in_if.valid & ~skid_vld_q;
  assign rel    = main_vld_q & out_if.ready;

  // Payload left in the main register when it goes empty: control is forced to a
  // NOP so downstream never sees stale RegWrite/MemWrite bits; data is either kept
  // (cheap hold, useful for debug) or zeroed.
  function automatic entry_t bubble_of(input entry_t cur);
    entry_t b;
    b.ctrl = '0;
    b.data = (CLEAR_DATA != 0) ? '0 : cur.data;
    return b;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush_i) begin
      // A release in this cycle was already sampled downstream; an accept is dropped.
      state_q    <= ST_EMPTY;
      main_q     <= bubble_of(main_q);
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_q     <= in_ent;
            main_vld_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && rel) begin
            main_q <= in_ent;
          end else if (acc) begin
            // Downstream stalled but in_ready was already promised: park in skid.
            skid_q     <= in_ent;
            skid_vld_q <= 1'b1;
            state_q    <= ST_FULL;
          end else if (rel) begin
            main_q     <= bubble_of(main_q);
            main_vld_q <= 1'b0;
            state_q    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a release can move the state.
          if (rel) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          main_q     <= bubble_of(main_q);
          skid_q     <= '0;
          main_vld_q <= 1'b0;
          skid_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_if.ready  = ~skid_vld_q;
  assign out_if.valid = main_vld_q;
  assign out_if.ctrl  = main_q.ctrl;
  assign out_if.data  = main_q.data;
  assign occupancy_o  = state_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush only suppresses the bubble count, never clears.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_vld_q && !out_if.ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!main_vld_q && !flush_i && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: two instances (CLEAR_DATA=0 and 1) share one stimulus.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_pipe_stage_elastic;
  localparam int CW = 12;
  localparam int DW = 128;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occ1;
  logic [1:0] occ2;
  int         n_chk  = 0;
  int         n_pass = 0;

  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) in1 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) out1 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) in2 ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) out2 ();

  assign in2.valid  = in1.valid;
  assign in2.ctrl   = in1.ctrl;
  assign in2.data   = in1.data;
  assign out2.ready = out1.ready;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall1, bubble1, stall2, bubble2;
`endif

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0)) u_dut_hold (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_if        (in1),
    .out_if       (out1),
    .occupancy_o  (occ1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall1),
    .bubble_cnt_o (bubble1)
`endif
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) u_dut_clr (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_if        (in2),
    .out_if       (out2),
    .occupancy_o  (occ2)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall2),
    .bubble_cnt_o (bubble2)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    in1.valid  = v;
    in1.ctrl   = c;
    in1.data   = d;
    out1.ready = r;
  endtask

  // Common "stage is empty" expectations for the hold instance.
  task automatic chk_empty(input string tag);
    chk({tag, "_vld"},  128'(out1.valid), 128'(0));
    chk({tag, "_ctrl"}, 128'(out1.ctrl),  128'(0));
    chk({tag, "_occ"},  128'(occ1),       128'(0));
    chk({tag, "_rdy"},  128'(in1.ready),  128'(1));
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);

    // ---------------- reset state ----------------
    #3;
    chk_empty("rst");
    chk("rst_dat",     out1.data,         128'(0));
    chk("rst_dat_clr", out2.data,         128'(0));
    chk("rst_occ_clr", 128'(occ2),        128'(0));
    tick();
    rst_n = 1'b1;

    // ---------------- stream 1..8, out_ready high ----------------
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k), DW'(k), 1'b1);
      tick();
      chk($sformatf("strm_vld%0d", k),  128'(out1.valid), 128'(1));
      chk($sformatf("strm_dat%0d", k),  out1.data,        128'(k));
      chk($sformatf("strm_ctrl%0d", k), 128'(out1.ctrl),  128'(k));
      chk($sformatf("strm_occ%0d", k),  128'(occ1),       128'(1));
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk_empty("drain");
    chk("drain_hold", out1.data, 128'(8));
    chk("drain_clr",  out2.data, 128'(0));

    // ---------------- bubble with all-ones control ----------------
    drive(1'b1, 12'hFFF, 128'h77, 1'b1);
    tick();
    chk("bub_ctrl_live", 128'(out1.ctrl), 128'(12'hFFF));
    chk("bub_dat_live2", out2.data,       128'h77);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk("bub_ctrl",      128'(out1.ctrl), 128'(0));
    chk("bub_ctrl_clr",  128'(out2.ctrl), 128'(0));
    chk("bub_dat_hold",  out1.data,       128'h77);
    chk("bub_dat_clr",   out2.data,       128'(0));
    tick();
    chk("bub_dat_hold2", out1.data,       128'h77);

    // ---------------- back-pressure A,B,C ----------------
    drive(1'b1, 12'h00A, 128'hA, 1'b1);
    tick();
    chk("bp_a_dat", out1.data,  128'hA);
    chk("bp_a_occ", 128'(occ1), 128'(1));
    drive(1'b1, 12'h00B, 128'hB, 1'b0);
    tick();
    chk("bp_full_occ", 128'(occ1),      128'(2));
    chk("bp_full_rdy", 128'(in1.ready), 128'(0));
    chk("bp_full_dat", out1.data,       128'hA);
    drive(1'b1, 12'h00C, 128'hC, 1'b0);
    tick();
    chk("bp_hold_occ",  128'(occ1),      128'(2));
    chk("bp_hold_dat",  out1.data,       128'hA);
    chk("bp_hold_ctrl", 128'(out1.ctrl), 128'(12'h00A));
    chk("bp_hold_rdy",  128'(in1.ready), 128'(0));
    drive(1'b1, 12'h00C, 128'hC, 1'b1);
    tick();
    chk("bp_b_dat", out1.data,       128'hB);
    chk("bp_b_occ", 128'(occ1),      128'(1));
    chk("bp_b_rdy", 128'(in1.ready), 128'(1));
    tick();
    chk("bp_c_dat", out1.data,       128'hC);
    chk("bp_c_vld", 128'(out1.valid), 128'(1));
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk_empty("bp_end");

    // ---------------- flush when FULL ----------------
    drive(1'b1, 12'h010, 128'h10, 1'b0);
    tick();
    drive(1'b1, 12'h011, 128'h11, 1'b0);
    tick();
    chk("fl_pre_occ", 128'(occ1), 128'(2));
    drive(1'b1, 12'h00D, 128'hD, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_empty("flush");
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk("fl_no_d_vld", 128'(out1.valid), 128'(0));
    chk("fl_no_d_occ", 128'(occ1),       128'(0));

    // ---------------- async reset mid-stall ----------------
    drive(1'b1, 12'h020, 128'h20, 1'b0);
    tick();
    drive(1'b1, 12'h021, 128'h21, 1'b0);
    tick();
    chk("ar_pre_occ", 128'(occ1), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("arst");
    chk("arst_dat", out1.data, 128'(0));
    rst_n = 1'b1;
    drive(1'b1, 12'h055, 128'h55, 1'b1);
    tick();
    chk("ar_new_vld", 128'(out1.valid), 128'(1));
    chk("ar_new_dat", out1.data,        128'h55);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    chk_empty("ar_end");

`ifdef PIPE_STAGE_PERF_CNT_EN
    // ---------------- performance counters ----------------
    rst_n = 1'b0;
    #1;
    chk("pc_rst_stall",  128'(stall1),  128'(0));
    chk("pc_rst_bubble", 128'(bubble1), 128'(0));
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    tick(); tick(); tick();
    chk("pc_idle_bubble", 128'(bubble1), 128'(3));
    drive(1'b1, 12'h066, 128'h66, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("pc_stall",  128'(stall1),  128'(5));
    chk("pc_bubble", 128'(bubble1), 128'(4));
    drive(1'b0, '0, '0, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pc_fl_bubble", 128'(bubble1), 128'(4));
    chk("pc_fl_stall",  128'(stall1),  128'(5));
    tick();
    chk("pc_post_bubble", 128'(bubble1), 128'(5));
    chk("pc_clr_stall",   128'(stall2),  128'(5));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
